// File: rtl/wbm_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone-style bus arbiter:
// default bus widths and the arbiter state encoding.
package wbm_arbiter_pkg;

   localparam int ADDR_W_DEF = 64;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/wbm_arbiter_reqbuf.sv
// One-deep request buffer for a single master: latches a strobed request
// and presents it (or the request arriving this cycle) to the arbiter.
module wbm_reqbuf
   import wbm_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              stb_i,
   input  logic [ADDR_W-1:0] adr_i,
   input  logic [DATA_W-1:0] dat_i,
   input  logic              we_i,
   input  logic              clr_i,
   output logic              req_o,
   output logic [ADDR_W-1:0] adr_o,
   output logic [DATA_W-1:0] dat_o,
   output logic              we_o
);

   logic              pending_q;
   logic [ADDR_W-1:0] adr_q;
   logic [DATA_W-1:0] dat_q;
   logic              we_q;
   logic              capture;

   // A completing request frees the slot on the same edge, so a new strobe can land there.
   assign capture = stb_i & (~pending_q | clr_i);

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         pending_q <= 1'b0;
      end else if (capture) begin
         pending_q <= 1'b1;
      end else if (clr_i) begin
         pending_q <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (capture) begin
         adr_q <= adr_i;
         dat_q <= dat_i;
         we_q  <= we_i;
      end
   end

   // Bypass lets a request strobed while idle be granted on the capturing edge.
   assign req_o = pending_q | stb_i;
   assign adr_o = pending_q ? adr_q : adr_i;
   assign dat_o = pending_q ? dat_q : dat_i;
   assign we_o  = pending_q ? we_q  : we_i;

endmodule

// File: rtl/wbm_arbiter.sv
// Round-robin arbiter sharing one Wishbone-style slave bus between the
// instruction-fetch master (m0) and the load/store master (m1).
module wbm_arbiter
   import wbm_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [ADDR_W-1:0] m0adr_i,
   input  logic [DATA_W-1:0] m0dat_i,
   input  logic              m0we_i,
   input  logic              m0stb_i,
   output logic              m0ack_o,
   output logic [DATA_W-1:0] m0dat_o,
   input  logic [ADDR_W-1:0] m1adr_i,
   input  logic [DATA_W-1:0] m1dat_i,
   input  logic              m1we_i,
   input  logic              m1stb_i,
   output logic              m1ack_o,
   output logic [DATA_W-1:0] m1dat_o,
   output logic [ADDR_W-1:0] sadr_o,
   output logic [DATA_W-1:0] sdat_o,
   output logic              swe_o,
   output logic              sstb_o,
   input  logic              sack_i,
   input  logic [DATA_W-1:0] sdat_i,
   output logic              owner_o,
   output logic              busy_o
);

   arb_state_e        state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic              grant, load;
   logic              busy, done;
   logic              req0, req1;
   logic              clr0, clr1;
   logic [ADDR_W-1:0] adr0, adr1, sadr_q;
   logic [DATA_W-1:0] dat0, dat1, sdat_q;
   logic              we0, we1, swe_q;

   wbm_reqbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf0 (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .stb_i  (m0stb_i),
      .adr_i  (m0adr_i),
      .dat_i  (m0dat_i),
      .we_i   (m0we_i),
      .clr_i  (clr0),
      .req_o  (req0),
      .adr_o  (adr0),
      .dat_o  (dat0),
      .we_o   (we0)
   );

   wbm_reqbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf1 (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .stb_i  (m1stb_i),
      .adr_i  (m1adr_i),
      .dat_i  (m1dat_i),
      .we_i   (m1we_i),
      .clr_i  (clr1),
      .req_o  (req1),
      .adr_o  (adr1),
      .dat_o  (dat1),
      .we_o   (we1)
   );

   assign busy = (state_q != IDLE);
   assign done = busy & sack_i;
   assign clr0 = done & ~owner_q;
   assign clr1 = done &  owner_q;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      load    = 1'b0;
      grant   = owner_q;
      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               grant   = (req0 & req1) ? ~last_q : req1;
               load    = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE, WAIT: begin
            if (sack_i) begin
               last_d = owner_q;
               // Only the other master may follow directly; the owner re-contends from IDLE.
               if (owner_q ? req0 : req1) begin
                  grant   = ~owner_q;
                  load    = 1'b1;
                  state_d = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = WAIT;
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         owner_d = grant;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         sadr_q  <= '0;
         sdat_q  <= '0;
         swe_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         if (load) begin
            sadr_q <= grant ? adr1 : adr0;
            sdat_q <= grant ? dat1 : dat0;
            swe_q  <= grant ? we1  : we0;
         end
      end
   end

   assign sstb_o  = (state_q == ISSUE);
   assign busy_o  = busy;
   assign owner_o = owner_q;
   assign sadr_o  = sadr_q;
   assign sdat_o  = sdat_q;
   assign swe_o   = swe_q;
   assign m0ack_o = done & ~owner_q;
   assign m1ack_o = done &  owner_q;
   assign m0dat_o = sdat_i;
   assign m1dat_o = sdat_i;

endmodule

// File: tb/tb_wbm_arbiter.sv
// Self-checking bench for wbm_arbiter: directed scenarios plus random traffic
// scored against a transaction-level model of the arbitration rules.
module tb_wbm_arbiter;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 16;

   logic              clk_i = 1'b0;
   logic              reset_i = 1'b0;
   logic [ADDR_W-1:0] m0adr_i, m1adr_i;
   logic [DATA_W-1:0] m0dat_i, m1dat_i;
   logic              m0we_i, m1we_i, m0stb_i, m1stb_i;
   logic              m0ack_o, m1ack_o;
   logic [DATA_W-1:0] m0dat_o, m1dat_o;
   logic [ADDR_W-1:0] sadr_o;
   logic [DATA_W-1:0] sdat_o;
   logic              swe_o, sstb_o, sack_i;
   logic [DATA_W-1:0] sdat_i;
   logic              owner_o, busy_o;

   always #5 clk_i = ~clk_i;

   wbm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .m0adr_i(m0adr_i), .m0dat_i(m0dat_i), .m0we_i(m0we_i), .m0stb_i(m0stb_i),
      .m0ack_o(m0ack_o), .m0dat_o(m0dat_o),
      .m1adr_i(m1adr_i), .m1dat_i(m1dat_i), .m1we_i(m1we_i), .m1stb_i(m1stb_i),
      .m1ack_o(m1ack_o), .m1dat_o(m1dat_o),
      .sadr_o(sadr_o), .sdat_o(sdat_o), .swe_o(swe_o), .sstb_o(sstb_o),
      .sack_i(sack_i), .sdat_i(sdat_i),
      .owner_o(owner_o), .busy_o(busy_o)
   );

   typedef struct {
      logic [ADDR_W-1:0] adr;
      logic [DATA_W-1:0] dat;
      logic              we;
      logic              owner;
   } exp_t;

   exp_t exp_q[$];
   exp_t t_e, t_m;
   int   checks = 0;
   int   errors = 0;
   int   n_issued = 0;

   // Reference model state: one request slot per master plus who owns the bus.
   bit                m_pend[2];
   logic [ADDR_W-1:0] m_adr[2];
   logic [DATA_W-1:0] m_dat[2];
   logic              m_we[2];
   bit                m_last = 1'b1;
   bit                m_busy = 1'b0;
   bit                m_owner = 1'b0;
   bit                m_issue = 1'b0;
   bit                t_was_busy, t_done;
   int                t_g;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   initial forever begin
      @(posedge clk_i or negedge reset_i);
      if (!reset_i) begin
         m_pend[0] = 1'b0;
         m_pend[1] = 1'b0;
         m_last    = 1'b1;
         m_busy    = 1'b0;
         m_owner   = 1'b0;
         m_issue   = 1'b0;
         exp_q.delete();
      end else begin
         t_was_busy = m_busy;
         t_done     = m_busy && sack_i;
         m_issue    = 1'b0;
         if (t_done) begin
            m_pend[m_owner] = 1'b0;
            m_last = m_owner;
            m_busy = 1'b0;
         end
         if (m0stb_i && !m_pend[0]) begin
            m_pend[0] = 1'b1; m_adr[0] = m0adr_i; m_dat[0] = m0dat_i; m_we[0] = m0we_i;
         end
         if (m1stb_i && !m_pend[1]) begin
            m_pend[1] = 1'b1; m_adr[1] = m1adr_i; m_dat[1] = m1dat_i; m_we[1] = m1we_i;
         end
         t_g = -1;
         if (!t_was_busy) begin
            if (m_pend[0] && m_pend[1]) t_g = m_last ? 0 : 1;
            else if (m_pend[0])         t_g = 0;
            else if (m_pend[1])         t_g = 1;
         end else if (t_done && m_pend[m_owner ? 0 : 1]) begin
            t_g = m_owner ? 0 : 1;
         end
         if (t_g >= 0) begin
            m_busy    = 1'b1;
            m_owner   = (t_g == 1);
            m_issue   = 1'b1;
            t_e.adr   = m_adr[t_g];
            t_e.dat   = m_dat[t_g];
            t_e.we    = m_we[t_g];
            t_e.owner = (t_g == 1);
            exp_q.push_back(t_e);
         end
      end
   end

   initial forever begin
      @(negedge clk_i);
      if (reset_i) begin
         chk("sstb", sstb_o, m_issue);
         chk("busy", busy_o, m_busy);
         chk("owner", owner_o, m_owner);
         chk("m0ack", m0ack_o, sack_i & m_busy & ~m_owner);
         chk("m1ack", m1ack_o, sack_i & m_busy & m_owner);
         chk("m0dat", m0dat_o, sdat_i);
         chk("m1dat", m1dat_o, sdat_i);
         if (sstb_o) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL issue: sstb_o high with no expected transaction at %0t", $time);
            end else begin
               t_m = exp_q.pop_front();
               n_issued++;
               chk("issue owner", owner_o, t_m.owner);
            end
         end
         if (m_busy) begin
            chk("hold adr", sadr_o, t_m.adr);
            chk("hold dat", sdat_o, t_m.dat);
            chk("hold we", swe_o, t_m.we);
         end
      end
   end

   initial begin
      m0adr_i = '0; m1adr_i = '0; m0dat_i = '0; m1dat_i = '0;
      m0we_i = 1'b0; m1we_i = 1'b0; m0stb_i = 1'b0; m1stb_i = 1'b0;
      sack_i = 1'b1; sdat_i = '0;
      repeat (3) cyc();
      chk("rst sstb", sstb_o, 0);
      chk("rst busy", busy_o, 0);
      chk("rst owner", owner_o, 0);
      chk("rst sadr", sadr_o, 0);
      chk("rst sdat", sdat_o, 0);
      chk("rst swe", swe_o, 0);
      chk("rst m0ack", m0ack_o, 0);
      chk("rst m1ack", m1ack_o, 0);
      sack_i = 1'b0;
      reset_i = 1'b1;

      // Single m1 transaction with a two-cycle slave wait
      cyc();
      m1stb_i = 1'b1; m1adr_i = 64'h1122334455667788; m1dat_i = 16'h1100; m1we_i = 1'b1;
      cyc(); m1stb_i = 1'b0; #2;
      chk("single sstb", sstb_o, 1);
      chk("single sadr", sadr_o, 64'h1122334455667788);
      chk("single sdat", sdat_o, 16'h1100);
      chk("single swe", swe_o, 1);
      chk("single owner", owner_o, 1);
      cyc(); #2;
      chk("single wait sstb", sstb_o, 0);
      chk("single wait busy", busy_o, 1);
      cyc(); sack_i = 1'b1; sdat_i = 16'hDEAD; #2;
      chk("single m1ack", m1ack_o, 1);
      chk("single m1dat", m1dat_o, 16'hDEAD);
      chk("single m0ack", m0ack_o, 0);
      cyc(); sack_i = 1'b0; #2;
      chk("single idle busy", busy_o, 0);

      // Tie straight after reset: m0 first, m1 follows with no gap
      reset_i = 1'b0; cyc(); reset_i = 1'b1;
      m0stb_i = 1'b1; m0adr_i = 64'h1000; m0dat_i = 16'h00A0; m0we_i = 1'b0;
      m1stb_i = 1'b1; m1adr_i = 64'h2000; m1dat_i = 16'h00B0; m1we_i = 1'b1;
      cyc(); m0stb_i = 1'b0; m1stb_i = 1'b0; sack_i = 1'b1; #2;
      chk("tie first sstb", sstb_o, 1);
      chk("tie first sadr", sadr_o, 64'h1000);
      chk("tie first owner", owner_o, 0);
      chk("tie m0ack", m0ack_o, 1);
      chk("tie m1ack idle", m1ack_o, 0);
      cyc(); #2;
      chk("tie second sstb", sstb_o, 1);
      chk("tie second sadr", sadr_o, 64'h2000);
      chk("tie second owner", owner_o, 1);
      chk("issue-cycle m1ack", m1ack_o, 1);
      cyc(); sack_i = 1'b0; #2;
      chk("issue-cycle ack busy", busy_o, 0);
      chk("issue-cycle ack sstb", sstb_o, 0);

      // Round-robin over three simultaneous request pairs
      for (int k = 0; k < 3; k++) begin
         m0stb_i = 1'b1; m0adr_i = 64'h3000 + 64'(k);
         m1stb_i = 1'b1; m1adr_i = 64'h4000 + 64'(k);
         cyc(); m0stb_i = 1'b0; m1stb_i = 1'b0;
         for (int j = 0; j < 2; j++) begin
            sack_i = 1'b1; #2;
            chk("rr sstb", sstb_o, 1);
            chk("rr owner", owner_o, 64'(j));
            chk("rr sadr", sadr_o, (j == 1) ? 64'h4000 + 64'(k) : 64'h3000 + 64'(k));
            cyc(); sack_i = 1'b0;
         end
      end

      // Duplicate strobe while pending is dropped
      m0stb_i = 1'b1; m0adr_i = 64'h100;
      cyc(); m0stb_i = 1'b0;
      cyc();
      m0stb_i = 1'b1; m0adr_i = 64'h200;
      cyc(); m0stb_i = 1'b0; #2;
      chk("dup sadr", sadr_o, 64'h100);
      chk("dup busy", busy_o, 1);
      sack_i = 1'b1; #1;
      chk("dup m0ack", m0ack_o, 1);
      cyc(); sack_i = 1'b0;
      for (int n = 0; n < 3; n++) begin
         #2;
         chk("dup no reissue", sstb_o, 0);
         chk("dup idle", busy_o, 0);
         cyc();
      end

      // Reset in WAIT drops the transaction
      m1stb_i = 1'b1; m1adr_i = 64'h5555; m1dat_i = 16'h1234; m1we_i = 1'b1;
      cyc(); m1stb_i = 1'b0;
      cyc(); #2;
      chk("pre-reset busy", busy_o, 1);
      reset_i = 1'b0; #1;
      chk("mid rst sstb", sstb_o, 0);
      chk("mid rst busy", busy_o, 0);
      chk("mid rst owner", owner_o, 0);
      chk("mid rst sadr", sadr_o, 0);
      chk("mid rst sdat", sdat_o, 0);
      chk("mid rst swe", swe_o, 0);
      cyc(); reset_i = 1'b1;
      cyc(); sack_i = 1'b1; #2;
      chk("late ack m0", m0ack_o, 0);
      chk("late ack m1", m1ack_o, 0);
      chk("late ack busy", busy_o, 0);
      cyc(); sack_i = 1'b0;

      // Random traffic against the model
      repeat (2000) begin
         cyc();
         m0stb_i = ($urandom_range(0, 3) == 0);
         m0adr_i = {$urandom, $urandom};
         m0dat_i = DATA_W'($urandom);
         m0we_i  = 1'($urandom_range(0, 1));
         m1stb_i = ($urandom_range(0, 3) == 0);
         m1adr_i = {$urandom, $urandom};
         m1dat_i = DATA_W'($urandom);
         m1we_i  = 1'($urandom_range(0, 1));
         sack_i  = ($urandom_range(0, 2) == 0);
         sdat_i  = DATA_W'($urandom);
      end
      cyc();
      m0stb_i = 1'b0; m1stb_i = 1'b0; sack_i = 1'b1;
      repeat (12) cyc();
      sack_i = 1'b0; #2;
      chk("drain", 64'(exp_q.size()), 0);
      chk("activity", 64'(n_issued > 100), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wbm_arbiter.md
WBM_ARBITER -- requirements
Module: wbm_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, address width.
REQ-002 SHALL have parameter DATA_W, default 16, data width.
REQ-003 SHALL have port clk_i  in  1  clock; all state on rising edge.
REQ-004 SHALL have port reset_i  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports m0adr_i/m1adr_i  in  ADDR_W  master address; m0 = instruction fetch, m1 = LSU.
REQ-006 SHALL have ports m0dat_i/m1dat_i  in  DATA_W  master write data.
REQ-007 SHALL have ports m0we_i/m1we_i  in  1  master write enable.
REQ-008 SHALL have ports m0stb_i/m1stb_i  in  1  request strobe; a one-cycle pulse per transaction.
REQ-009 SHALL have ports m0ack_o/m1ack_o  out  1  completion to the owning master.
REQ-010 SHALL have ports m0dat_o/m1dat_o  out  DATA_W  read data; both equal sdat_i.
REQ-011 SHALL have ports sadr_o  out  ADDR_W, sdat_o  out  DATA_W, swe_o  out  1, sstb_o  out  1; the shared-bus request.
REQ-012 SHALL have ports sack_i  in  1, sdat_i  in  DATA_W; shared-bus response.
REQ-013 SHALL have port owner_o  out  1  master currently owning the shared bus (0/1).
REQ-014 SHALL have port busy_o  out  1  high in ISSUE or WAIT.

Function
REQ-015 SHALL hold one request buffer per master: pending flag, adr, dat, we.
REQ-016 SHALL capture mNadr/dat/we and set pendingN on the rising edge where mNstb_i=1 and pendingN=0.
REQ-017 SHALL ignore mNstb_i while pendingN=1; the buffer stays unchanged.
REQ-018 SHALL implement states IDLE, ISSUE, WAIT.
REQ-019 SHALL, in IDLE with any pending bit set (or set this edge), select a winner and enter ISSUE on the next edge.
REQ-020 SHALL select round-robin among simultaneous pending: grant the master not granted last; a single pending master always wins.
REQ-021 SHALL, in ISSUE, drive sstb_o=1 for exactly one cycle, with sadr_o/sdat_o/swe_o taken from the winner's buffer.
REQ-022 SHALL drive sstb_o=0 in IDLE and WAIT.
REQ-023 SHALL hold sadr_o/sdat_o/swe_o stable from ISSUE through the ack cycle.
REQ-024 SHALL leave ISSUE for WAIT when sack_i=0.
REQ-025 SHALL treat sack_i=1 in ISSUE or WAIT as completion.
REQ-026 SHALL make mNack_o = sack_i AND busy AND owner==N, combinationally (zero added latency).
REQ-027 SHALL drive the non-owner ack to 0.
REQ-028 SHALL on completion clear the owner's pending bit and record the owner as last-granted.
REQ-029 SHALL on completion go to ISSUE (granting the other master) if the other master is pending, else to IDLE; no idle gap between back-to-back transactions.
REQ-030 SHALL ignore sack_i in IDLE.
REQ-031 SHALL allow a master to capture a new request in the same edge its ack completes; it then contends normally.
REQ-032 SHALL never let the owner change between ISSUE and completion.

Reset
REQ-033 SHALL, on reset_i=0 (any cycle, including mid-transaction), force state IDLE, pending0=pending1=0, sstb_o=0, owner_o=0, busy_o=0, sadr_o=0, sdat_o=0, swe_o=0, and last-granted=1 (m0 wins the first tie).
REQ-034 SHALL drop any in-flight transaction on reset, with no ack delivered to either master.

Structure
REQ-035 SHALL place the state encoding (IDLE/ISSUE/WAIT) and the ADDR_W/DATA_W defaults in the shared CPU package.
REQ-036 SHALL implement the per-master request buffer as sub-module wbm_reqbuf, instantiated twice.

Verification
REQ-037 SHALL verify single m1 request: m1stb pulse, adr=64'h1122334455667788, dat=16'h1100, we=1 -> next cycle sstb_o=1 with those values, owner_o=1; sack_i=1 with sdat_i=16'hDEAD two cycles later -> m1ack_o=1, m1dat_o=16'hDEAD, m0ack_o=0.
REQ-038 SHALL verify tie after reset: m0 and m1 strobe on the same edge -> m0 issued first; on m0 ack, the next cycle sstb_o=1 with m1's address, owner_o=1.
REQ-039 SHALL verify round-robin: three consecutive simultaneous request pairs -> grant order m0,m1,m0,m1,m0,m1.
REQ-040 SHALL verify sack_i=1 in the ISSUE cycle -> owner ack in that same cycle, busy_o=0 next cycle if nothing pending.
REQ-041 SHALL verify a duplicate strobe: m0stb pulse with adr=0x100, then a second pulse with adr=0x200 while pending -> only 0x100 issued.
REQ-042 SHALL verify reset asserted in WAIT -> all outputs at reset values immediately; a later sack_i=1 produces no master ack.
